// File: rtl/bloon_pkg.sv
// Shared sprite geometry, transparency key and pixel/position types for the
// bloon sprite pixel path.
package bloon_pkg;

    localparam int          SPRITE_W = 32;
    localparam int          SPRITE_H = 32;
    localparam int          PIPE_LAT = 2;
    localparam logic [11:0] KEY_RGB  = 12'hF0F;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } bloon_pos_t;

endpackage

// File: rtl/bloon_sprite_driver_pix_delay.sv
// Fixed-depth, reset-cleared shift register used to realign per-pixel
// side information with the renderer's late RGB.
module pix_delay #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 2
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: the stages are cleared on reset so a stale hit/blank cannot leak
    // into the first pixels after reset; the array is small enough to be flops.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's
            // pre-edge value; blocking would collapse the line to one stage.
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/bloon_sprite_driver.sv
// Bloon sprite pixel-address generation, frame-synchronous position update,
// and transparent-key compositing over the background.
module bloon_sprite_driver
    import bloon_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       frame_start,
    input  logic       pos_valid,
    output logic       pos_ready,
    input  logic [9:0] BloonX,
    input  logic [9:0] BloonY,
    input  logic       bloon_en,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    input  logic [3:0] spr_red,
    input  logic [3:0] spr_green,
    input  logic [3:0] spr_blue,
    output logic [9:0] RelativeXB,
    output logic [9:0] RelativeYB,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       bloon_visible
);

    localparam int ALIGN_W = 2 + $bits(rgb_t);

    bloon_pos_t pend_q, pend_d, cur_q, cur_d;
    logic       pend_full_q, pend_full_d;
    logic       seen_q, seen_d;
    logic       vis_q, vis_d;
    rgb_t       pix_q, pix_d;

    logic [10:0]        x_end, y_end;
    logic               hit;
    rgb_t               bg_in, spr_in, bg_dl;
    logic               hit_dl, blank_dl, opaque;
    logic [ALIGN_W-1:0] align_in, align_out;

    assign bg_in  = '{r: bg_red,  g: bg_green,  b: bg_blue};
    assign spr_in = '{r: spr_red, g: spr_green, b: spr_blue};

    // Ends are one bit wider so a sprite near x=1023 does not wrap to column 0.
    always_comb begin
        x_end      = {1'b0, cur_q.x} + 11'(SPRITE_W);
        y_end      = {1'b0, cur_q.y} + 11'(SPRITE_H);
        hit        = cur_q.en
                     && (DrawX >= cur_q.x) && ({1'b0, DrawX} < x_end)
                     && (DrawY >= cur_q.y) && ({1'b0, DrawY} < y_end);
        RelativeXB = hit ? DrawX - cur_q.x : '0;
        RelativeYB = hit ? DrawY - cur_q.y : '0;
    end

    assign align_in                     = {hit, blank, bg_in};
    assign {hit_dl, blank_dl, bg_dl}    = align_out;

    pix_delay #(
        .WIDTH (ALIGN_W),
        .DEPTH (PIPE_LAT)
    ) u_align (
        .vga_clk (vga_clk),
        .reset   (reset),
        .din     (align_in),
        .dout    (align_out)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cur_d       = cur_q;
        seen_d      = seen_q;
        vis_d       = vis_q;
        pix_d       = bg_dl;

        // Commit reads the pre-edge full flag, so a same-cycle offer waits a frame.
        if (frame_start && pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
        end
        if (pos_valid && !pend_full_q) begin
            pend_d      = '{x: BloonX, y: BloonY, en: bloon_en};
            pend_full_d = 1'b1;
        end

        opaque = blank_dl && hit_dl && (spr_in != KEY_RGB);
        if (!blank_dl) begin
            pix_d = '0;
        end else if (opaque) begin
            pix_d = spr_in;
        end

        if (frame_start) begin
            vis_d  = seen_q;
            seen_d = 1'b0;
        end else if (opaque) begin
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cur_q       <= '0;
            seen_q      <= 1'b0;
            vis_q       <= 1'b0;
            pix_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cur_q       <= cur_d;
            seen_q      <= seen_d;
            vis_q       <= vis_d;
            pix_q       <= pix_d;
        end
    end

    assign pos_ready     = !pend_full_q;
    assign red           = pix_q.r;
    assign green         = pix_q.g;
    assign blue          = pix_q.b;
    assign bloon_visible = vis_q;

endmodule

// File: tb/tb_bloon_sprite_driver.sv
// Self-checking bench: directed scenarios followed by randomized frames, all
// compared against a cycle-history reference model of the sprite driver.
module tb_bloon_sprite_driver;

    localparam int          SW  = 32;
    localparam int          SH  = 32;
    localparam logic [11:0] KEY = 12'hF0F;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       blank = 1'b0, frame_start = 1'b0, pos_valid = 1'b0;
    logic [9:0] BloonX = '0, BloonY = '0;
    logic       bloon_en = 1'b0;
    logic [11:0] bg = '0, spr = '0;
    logic [3:0] bg_red, bg_green, bg_blue, spr_red, spr_green, spr_blue;
    logic       pos_ready, bloon_visible;
    logic [9:0] RelativeXB, RelativeYB;
    logic [3:0] red, green, blue;

    assign {bg_red, bg_green, bg_blue}    = bg;
    assign {spr_red, spr_green, spr_blue} = spr;

    always #5 vga_clk = ~vga_clk;

    bloon_sprite_driver dut (
        .vga_clk       (vga_clk),
        .reset         (reset),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .blank         (blank),
        .frame_start   (frame_start),
        .pos_valid     (pos_valid),
        .pos_ready     (pos_ready),
        .BloonX        (BloonX),
        .BloonY        (BloonY),
        .bloon_en      (bloon_en),
        .bg_red        (bg_red),
        .bg_green      (bg_green),
        .bg_blue       (bg_blue),
        .spr_red       (spr_red),
        .spr_green     (spr_green),
        .spr_blue      (spr_blue),
        .RelativeXB    (RelativeXB),
        .RelativeYB    (RelativeYB),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .bloon_visible (bloon_visible)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: architectural state plus a short history of what was
    // presented on each cycle, indexed by absolute cycle number.
    bit          m_valid = 1'b0;
    int          m_pend_x, m_pend_y, m_cur_x, m_cur_y;
    bit          m_pend_en, m_pend_full, m_cur_en, m_seen, m_vis;
    logic [11:0] m_rgb;
    int          cyc = 0;
    int          last_rst = -100;
    bit          h_hit[8];
    bit          h_blank[8];
    logic [11:0] h_bg[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluates the model for the inputs currently applied, compares, then
    // advances the model to the state it must hold after the coming edge.
    task automatic model_cycle();
        int  x, y, old;
        bit  hit, ob, oh, opq;
        logic [11:0] obg;
        x   = int'(DrawX);
        y   = int'(DrawY);
        hit = m_cur_en && x >= m_cur_x && x < m_cur_x + SW && y >= m_cur_y && y < m_cur_y + SH;
        if (m_valid) begin
            check("rel_x", 32'(RelativeXB), hit ? 32'(x - m_cur_x) : 32'd0);
            check("rel_y", 32'(RelativeYB), hit ? 32'(y - m_cur_y) : 32'd0);
            check("pos_ready", 32'(pos_ready), 32'(!m_pend_full));
            check("rgb", 32'({red, green, blue}), 32'(m_rgb));
            check("visible", 32'(bloon_visible), 32'(m_vis));
        end
        if (reset) begin
            m_valid = 1'b1;
            m_pend_x = 0; m_pend_y = 0; m_pend_en = 0; m_pend_full = 0;
            m_cur_x = 0; m_cur_y = 0; m_cur_en = 0;
            m_seen = 0; m_vis = 0; m_rgb = '0;
            last_rst = cyc;
        end else begin
            // Output register takes side info from two cycles ago and the RGB
            // the renderer returns now; anything from before reset reads as 0.
            old = cyc - 2;
            ob = 0; oh = 0; obg = '0;
            if (old > last_rst && old >= 0) begin
                ob = h_blank[old % 8]; oh = h_hit[old % 8]; obg = h_bg[old % 8];
            end
            opq   = ob && oh && (spr != KEY);
            m_rgb = !ob ? 12'h000 : (opq ? spr : obg);
            if (frame_start) begin
                m_vis  = m_seen;
                m_seen = 0;
            end else if (opq) begin
                m_seen = 1;
            end
            if (frame_start && m_pend_full) begin
                m_cur_x = m_pend_x; m_cur_y = m_pend_y; m_cur_en = m_pend_en;
                m_pend_full = 0;
            end else if (pos_valid && !m_pend_full) begin
                m_pend_x = int'(BloonX); m_pend_y = int'(BloonY); m_pend_en = bloon_en;
                m_pend_full = 1;
            end
        end
        h_hit[cyc % 8]   = hit;
        h_blank[cyc % 8] = blank;
        h_bg[cyc % 8]    = bg;
        cyc++;
    endtask

    task automatic tick();
        #1;
        model_cycle();
        @(negedge vga_clk);
        frame_start = 1'b0;
        pos_valid   = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    task automatic offer(input int x, input int y, input bit en);
        pos_valid = 1'b1;
        BloonX    = 10'(x);
        BloonY    = 10'(y);
        bloon_en  = en;
    endtask

    initial begin
        // Reset, then background passthrough with nothing committed.
        blank = 1'b1; bg = 12'h123; spr = 12'h000;
        reset = 1'b1; tick();
        reset = 1'b1; tick();
        repeat (5) tick();
        check("bg_after_reset", 32'({red, green, blue}), 32'h123);

        // Offered position waits for frame_start.
        offer(100, 50, 1'b1); tick();
        pix(131, 81); #1;
        check("ready_drops", 32'(pos_ready), 32'd0);
        check("no_sprite_pre_commit", 32'(RelativeXB), 32'd0);
        tick();
        frame_start = 1'b1; tick();
        pix(131, 81); #1;
        check("corner_rel_x", 32'(RelativeXB), 32'd31);
        check("corner_rel_y", 32'(RelativeYB), 32'd31);
        tick();
        pix(132, 81); #1;
        check("past_right_edge", 32'(RelativeXB), 32'd0);
        tick();

        // Opaque pixel arrives PIPE_LAT late and shows one cycle after that.
        bg = 12'h456;
        pix(100, 50); tick();
        pix(0, 0); tick();
        spr = 12'hF00; tick();
        spr = 12'h000;
        check("opaque_pixel", 32'({red, green, blue}), 32'hF00);
        tick();
        pix(100, 50); tick();
        pix(0, 0); tick();
        spr = KEY; tick();
        spr = 12'h000;
        check("key_shows_bg", 32'({red, green, blue}), 32'h456);
        tick();

        // Offer coincident with frame_start commits one frame later.
        frame_start = 1'b1; offer(200, 60, 1'b1); tick();
        check("visible_after_opaque", 32'(bloon_visible), 32'd1);
        pix(131, 81); #1;
        check("old_pos_kept", 32'(RelativeXB), 32'd31);
        tick();
        frame_start = 1'b1; tick();
        pix(210, 70); #1;
        check("new_pos_rel_x", 32'(RelativeXB), 32'd10);
        check("new_pos_rel_y", 32'(RelativeYB), 32'd10);
        tick();
        pix(131, 81); #1;
        check("old_pos_gone", 32'(RelativeXB), 32'd0);
        tick();

        // Right-edge straddle must not wrap to column 0.
        offer(1010, 100, 1'b1); tick();
        frame_start = 1'b1; tick();
        pix(1023, 100); #1;
        check("edge_rel_x", 32'(RelativeXB), 32'd13);
        tick();
        pix(5, 100); #1;
        check("no_wrap", 32'(RelativeXB), 32'd0);
        tick();

        // A frame with the bloon disabled reports not visible.
        offer(0, 0, 1'b0); repeat (4) tick();
        frame_start = 1'b1; tick();
        check("visible_frame_n", 32'(bloon_visible), 32'd1);
        repeat (5) tick();
        frame_start = 1'b1; tick();
        check("hidden_frame", 32'(bloon_visible), 32'd0);

        // Reset mid-line clears output and visibility immediately.
        offer(100, 50, 1'b1); tick();
        frame_start = 1'b1; tick();
        pix(110, 60); repeat (4) tick();
        frame_start = 1'b1; tick();
        check("visible_before_reset", 32'(bloon_visible), 32'd1);
        reset = 1'b1; tick();
        check("reset_rgb", 32'({red, green, blue}), 32'd0);
        check("reset_visible", 32'(bloon_visible), 32'd0);
        repeat (4) tick();

        // Randomized frames around the current sprite position.
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 60; k++) begin
                int tx, ty;
                tx = m_cur_x + int'($urandom_range(0, 50)) - 10;
                ty = m_cur_y + int'($urandom_range(0, 50)) - 10;
                pix(tx & 1023, ty & 1023);
                blank = ($urandom_range(0, 7) != 0);
                bg    = 12'($urandom);
                spr   = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    offer(($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                                      : int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 1023)),
                          ($urandom_range(0, 4) != 0));
                end
                frame_start = (k == 59);
                reset       = ($urandom_range(0, 299) == 0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
